// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a registered result strobe and IDLE/RUN sequencing of multi-cycle ops.
// Define ALU_CTRL_M_EXT_EN to enable MUL/DIV/REM decode and the latency counter.
module alu_ctrl_seq #(
  parameter int OP_W       = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            alu_valid_o,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            busy_o,
  output logic            illegal_o
);

  if (OP_W < 5 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
    $error("alu_ctrl_seq: illegal parameter value");
  end

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);

  logic [OP_W-1:0] base_op;
  logic [OP_W-1:0] dec_op;
  logic            dec_illegal;
  logic            accept;

  // Shared funct3 table for R and I arithmetic
  always_comb begin
    base_op = OP_AND;
    case (funct3_i)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == 7'b0000000)
          dec_op = base_op;
        else if (funct7_i == 7'b0100000 && funct3_i == 3'b000)
          dec_op = OP_SUB;
        else if (funct7_i == 7'b0100000 && funct3_i == 3'b101)
          dec_op = OP_SRA;
`ifdef ALU_CTRL_M_EXT_EN
        else if (funct7_i == 7'b0000001)
          dec_op = OP_W'(11) + OP_W'(funct3_i);
`endif
        else
          dec_illegal = 1'b1;
      end
      3'b001: begin
        if (funct3_i == 3'b101 && funct7_i[5])
          dec_op = OP_SRA;
        else if (funct3_i == 3'b001 && funct7_i != 7'b0000000)
          dec_illegal = 1'b1;
        else
          dec_op = base_op;
      end
      3'b010:  dec_op = OP_ADD;
      3'b011:  dec_op = OP_SUB;
      3'b100:  dec_op = OP_PASSB;
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [OP_W-1:0] op_reg;
  logic            illegal_reg;
  logic            valid_reg;

  assign ALU_Operation_o = op_reg;
  assign illegal_o       = illegal_reg;
  assign alu_valid_o     = valid_reg;

`ifdef ALU_CTRL_M_EXT_EN
  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_L + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             is_m;
  logic [CNT_W-1:0] lat_m1;
  logic             is_multi;

  assign is_m     = (ALU_Op_i == 3'b000) && (funct7_i == 7'b0000001);
  assign lat_m1   = funct3_i[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
  assign is_multi = is_m && (lat_m1 != '0);
  assign accept   = valid_i && ready_reg && !flush_i;
  assign ready_o  = ready_reg;
  assign busy_o   = busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      op_reg      <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (flush_i) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        ready_reg <= 1'b1;
        busy_reg  <= 1'b0;
      end else if (accept) begin
        op_reg      <= dec_op;
        illegal_reg <= dec_illegal;
        if (is_multi) begin
          state_reg <= RUN;
          cnt_reg   <= lat_m1;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b1;
        end else begin
          // L=1 ops complete immediately but still flag busy for their one cycle
          state_reg <= IDLE;
          cnt_reg   <= '0;
          ready_reg <= 1'b1;
          busy_reg  <= is_m;
          valid_reg <= 1'b1;
        end
      end else if (state_reg == RUN) begin
        if (cnt_reg == CNT_W'(1)) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          ready_reg <= 1'b1;
          valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end else begin
        ready_reg <= 1'b1;
        busy_reg  <= 1'b0;
      end
    end
  end
`else
  assign accept  = valid_i && !flush_i;
  assign ready_o = 1'b1;
  assign busy_o  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      op_reg      <= '0;
    end else begin
      valid_reg <= accept;
      if (accept) begin
        op_reg      <= dec_op;
        illegal_reg <= dec_illegal;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected results, a monitor pops on alu_valid_o.
// Adds the M-extension timing cases when ALU_CTRL_M_EXT_EN is defined.
module tb_alu_ctrl_seq;
  localparam int OP_W = 5;

  logic            clk;
  logic            reset;
  logic            valid_i;
  logic [6:0]      funct7_i;
  logic [2:0]      ALU_Op_i;
  logic [2:0]      funct3_i;
  logic            flush_i;
  logic            ready_o;
  logic            alu_valid_o;
  logic [OP_W-1:0] alu_operation;
  logic            busy_o;
  logic            illegal_o;

  typedef struct {
    logic [OP_W-1:0] op;
    logic            ill;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .funct7_i       (funct7_i),
    .ALU_Op_i       (ALU_Op_i),
    .funct3_i       (funct3_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .alu_valid_o    (alu_valid_o),
    .ALU_Operation_o(alu_operation),
    .busy_o         (busy_o),
    .illegal_o      (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (alu_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got op %0d with no result expected", alu_operation);
      end else begin
        e = exp_q.pop_front();
        $display("txn result op=%0d illegal=%0d (expected op=%0d illegal=%0d)",
                 alu_operation, illegal_o, e.op, e.ill);
        chk("result_op", 32'(alu_operation), 32'(e.op));
        chk("result_illegal", 32'(illegal_o), 32'(e.ill));
      end
    end
  end

  // Drives one request for one cycle; input edge is the acceptance edge k, returns just after it
  task automatic send(input logic [2:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                      input int eop, input logic eill, input bit expect_out);
    exp_t e;
    valid_i  = 1'b1;
    ALU_Op_i = aop;
    funct7_i = f7;
    funct3_i = f3;
    if (expect_out) begin
      e.op  = OP_W'(eop);
      e.ill = eill;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_exp[8];
    r_exp = '{0, 5, 8, 9, 4, 6, 3, 2};

    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    funct7_i = '0; ALU_Op_i = '0; funct3_i = '0;
    idle(3);
    @(negedge clk);
    chk("reset_ready", 32'(ready_o), 1);
    chk("reset_valid", 32'(alu_valid_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_illegal", 32'(illegal_o), 0);
    chk("reset_op", 32'(alu_operation), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R SUB, result next cycle with ready still high
    send(3'b000, 7'b0100000, 3'b000, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("sub_valid", 32'(alu_valid_o), 1);
    chk("sub_ready", 32'(ready_o), 1);
    chk("sub_busy", 32'(busy_o), 0);
    @(posedge clk); #1;

    // I-class SRA followed back-to-back by load/store ADD
    send(3'b001, 7'b0100000, 3'b101, 7, 1'b0, 1'b1);
    send(3'b010, 7'b1010101, 3'b011, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_second_valid", 32'(alu_valid_o), 1);
    @(posedge clk); #1;

    // R-class base table, back-to-back
    for (int i = 0; i < 8; i++)
      send(3'b000, 7'b0000000, 3'(i), r_exp[i], 1'b0, 1'b1);
    send(3'b000, 7'b0100000, 3'b101, 7, 1'b0, 1'b1);   // SRA
    send(3'b000, 7'b0100000, 3'b010, 0, 1'b1, 1'b1);   // illegal pair
    send(3'b000, 7'b1111111, 3'b000, 0, 1'b1, 1'b1);   // illegal funct7
    send(3'b001, 7'b0000001, 3'b001, 0, 1'b1, 1'b1);   // I SLLI needs f7=0
    send(3'b001, 7'b0000000, 3'b001, 5, 1'b0, 1'b1);   // SLLI
    send(3'b001, 7'b0000000, 3'b101, 6, 1'b0, 1'b1);   // SRLI
    send(3'b001, 7'b1111111, 3'b010, 8, 1'b0, 1'b1);   // SLTI, f7 ignored
    send(3'b001, 7'b0100000, 3'b000, 0, 1'b0, 1'b1);   // ADDI, f7 ignored
    send(3'b011, 7'b0000000, 3'b111, 1, 1'b0, 1'b1);   // branch -> SUB
    send(3'b100, 7'b0110011, 3'b010, 10, 1'b0, 1'b1);  // LUI -> PASSB
    send(3'b101, 7'b0000000, 3'b000, 0, 1'b1, 1'b1);   // illegal class
    send(3'b100, 7'b0000000, 3'b000, 10, 1'b0, 1'b1);  // PASSB so the next illegal op visibly resets to 0
    send(3'b111, 7'b0000000, 3'b000, 0, 1'b1, 1'b1);   // illegal class 111
    @(negedge clk);
    chk("illegal111_flag", 32'(illegal_o), 1);
    chk("illegal111_op", 32'(alu_operation), 0);
    chk("illegal111_ready", 32'(ready_o), 1);
    @(posedge clk); #1;

`ifdef ALU_CTRL_M_EXT_EN
    // MUL with MUL_CYCLES=2
    send(3'b000, 7'b0000001, 3'b000, 11, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul_c1_busy", 32'(busy_o), 1);
    chk("mul_c1_ready", 32'(ready_o), 0);
    chk("mul_c1_valid", 32'(alu_valid_o), 0);
    @(negedge clk);
    chk("mul_c2_busy", 32'(busy_o), 1);
    chk("mul_c2_ready", 32'(ready_o), 1);
    @(posedge clk); #1;

    // DIV with DIV_CYCLES=32
    send(3'b000, 7'b0000001, 3'b100, 15, 1'b0, 1'b1);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      chk("div_busy", 32'(busy_o), 1);
      chk("div_ready", 32'(ready_o), (j == 32) ? 1 : 0);
      chk("div_valid", 32'(alu_valid_o), (j == 32) ? 1 : 0);
      chk("div_op", 32'(alu_operation), 15);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("div_after_busy", 32'(busy_o), 0);
    @(posedge clk); #1;

    // Flush during DIV at k+5; flushed op never produces a result
    send(3'b000, 7'b0000001, 3'b101, 16, 1'b0, 1'b0);
    idle(4);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_ready", 32'(ready_o), 1);
    chk("flush_valid", 32'(alu_valid_o), 0);
    chk("flush_op_hold", 32'(alu_operation), 16);
    @(posedge clk); #1;

    // Reset mid-RUN
    send(3'b000, 7'b0000001, 3'b110, 17, 1'b0, 1'b0);
    idle(3);
    reset = 1'b1; valid_i = 1'b1; ALU_Op_i = 3'b100;
    @(posedge clk); #1;
    reset = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("midrun_reset_busy", 32'(busy_o), 0);
    chk("midrun_reset_ready", 32'(ready_o), 1);
    chk("midrun_reset_valid", 32'(alu_valid_o), 0);
    chk("midrun_reset_op", 32'(alu_operation), 0);
    chk("midrun_reset_illegal", 32'(illegal_o), 0);
    @(posedge clk); #1;
`else
    // Without the M extension funct7=0000001 is illegal and never busy
    send(3'b000, 7'b0000001, 3'b000, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("noext_busy", 32'(busy_o), 0);
    chk("noext_illegal", 32'(illegal_o), 1);
    @(negedge clk);
    chk("noext_busy_later", 32'(busy_o), 0);
    chk("noext_ready_later", 32'(ready_o), 1);
    @(posedge clk); #1;
`endif

    // Outputs hold while nothing is accepted
    send(3'b000, 7'b0000000, 3'b100, 4, 1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    chk("hold_op", 32'(alu_operation), 4);
    chk("hold_illegal", 32'(illegal_o), 0);
    chk("hold_valid", 32'(alu_valid_o), 0);
    @(posedge clk); #1;

    // Flush together with valid: request dropped, op holds
    valid_i = 1'b1; flush_i = 1'b1; ALU_Op_i = 3'b100;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flushvalid_valid", 32'(alu_valid_o), 0);
    chk("flushvalid_op_hold", 32'(alu_operation), 4);
    @(posedge clk); #1;

    // Reset overrides a simultaneous request
    send(3'b000, 7'b0000000, 3'b110, 3, 1'b0, 1'b1);
    reset = 1'b1; valid_i = 1'b1; ALU_Op_i = 3'b111;
    @(posedge clk); #1;
    reset = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("reset_override_op", 32'(alu_operation), 0);
    chk("reset_override_illegal", 32'(illegal_o), 0);
    chk("reset_override_valid", 32'(alu_valid_o), 0);
    chk("reset_override_ready", 32'(ready_o), 1);

    idle(3);
    chk("pending_results", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter OP_W, default 5, ALU_Operation_o width; legal values >= 5.
REQ-002 SHALL have parameter MUL_CYCLES, default 2, multiply latency in cycles; legal values >= 1.
REQ-003 SHALL have parameter DIV_CYCLES, default 32, divide/remainder latency in cycles; legal values >= 1.
REQ-004 SHALL have port clk  input  1  clock; rising edge only.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_i  input  1  decode request.
REQ-007 SHALL have port funct7_i  input  7  instruction funct7.
REQ-008 SHALL have port ALU_Op_i  input  3  class from main control: 000 R, 001 I-arith, 010 load/store, 011 branch, 100 LUI; others illegal.
REQ-009 SHALL have port funct3_i  input  3  instruction funct3.
REQ-010 SHALL have port flush_i  input  1  abort current/pending operation.
REQ-011 SHALL have port ready_o  output  1  request can be accepted this cycle.
REQ-012 SHALL have port alu_valid_o  output  1  one-cycle result-ready strobe.
REQ-013 SHALL have port ALU_Operation_o  output  OP_W  registered ALU operation code.
REQ-014 SHALL have port busy_o  output  1  multi-cycle operation in progress.
REQ-015 SHALL have port illegal_o  output  1  accepted request had no legal decode; qualified by alu_valid_o.

Function
REQ-016 SHALL use codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10, MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18, zero-extended to OP_W.
REQ-017 SHALL decode R class: funct7 0000000 -> f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7 0100000 -> f3 000 SUB, 101 SRA; other funct7/f3 pairs illegal except REQ-030.
REQ-018 SHALL decode I class by funct3 as R class with funct7 ignored, except f3 101 with funct7[5]=1 -> SRA and f3 001 requires funct7 0000000.
REQ-019 SHALL decode load/store -> ADD, branch -> SUB, LUI -> PASSB, all independent of funct3/funct7.
REQ-020 SHALL accept a request on a rising edge where valid_i=1, ready_o=1, flush_i=0.
REQ-021 SHALL, for a single-cycle op accepted at edge k, drive ALU_Operation_o and alu_valid_o=1 in cycle k+1 only, with ready_o remaining 1 (back-to-back acceptance).
REQ-022 SHALL, for a multi-cycle op of latency L accepted at edge k, hold ALU_Operation_o from cycle k+1 until next acceptance, drive busy_o=1 in cycles k+1..k+L, ready_o=0 in cycles k+1..k+L-1, alu_valid_o=1 in cycle k+L only.
REQ-023 SHALL treat L=1 exactly as a single-cycle op with busy_o=1 for one cycle.
REQ-024 SHALL implement states IDLE, RUN; IDLE->RUN on acceptance of op with L>1; RUN->IDLE when down-counter reaches 1, unless a new request is accepted on that edge.
REQ-025 SHALL size the counter $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) bits, loaded with L-1 on acceptance, no wrap-around.
REQ-026 SHALL, on illegal decode, output ADD, illegal_o=1 and alu_valid_o=1 in cycle k+1, ready_o unaffected.
REQ-027 SHALL, on flush_i=1, return to IDLE next cycle with alu_valid_o=0, busy_o=0, ready_o=1, ignoring valid_i in that cycle; ALU_Operation_o holds.
REQ-028 SHALL keep ALU_Operation_o and illegal_o unchanged when no request is accepted.

Reset
REQ-029 SHALL, on clock edge with reset=1, enter IDLE: ready_o=1, alu_valid_o=0, busy_o=0, illegal_o=0, ALU_Operation_o=0, counter 0; reset overrides flush_i and valid_i, including mid-RUN.

Configuration
REQ-030 SHALL, with macro ALU_CTRL_M_EXT_EN defined, decode R class funct7 0000001 f3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with L=MUL_CYCLES for codes 11..14, DIV_CYCLES for 15..18.
REQ-031 SHALL, with ALU_CTRL_M_EXT_EN undefined, treat funct7 0000001 as illegal, contain no counter/RUN logic, keep busy_o=0 and ready_o=1 outside reset.

Verification
REQ-032 SHALL cover: reset, then R f7=0100000 f3=000 valid one cycle -> next cycle ALU_Operation_o=1, alu_valid_o=1, ready_o=1.
REQ-033 SHALL cover: I class f3=101 f7=0100000 then load/store back-to-back -> SRA(7) then ADD(0) in consecutive cycles, two alu_valid_o pulses.
REQ-034 SHALL cover (M_EXT_EN, DIV_CYCLES=32): DIV accepted edge k -> busy_o k+1..k+32, ready_o=0 k+1..k+31, single alu_valid_o at k+32, ALU_Operation_o=15.
REQ-035 SHALL cover: flush_i at k+5 during DIV -> cycle k+6 busy_o=0, ready_o=1, no alu_valid_o; flush_i with valid_i same cycle -> not accepted.
REQ-036 SHALL cover: ALU_Op_i=111 -> illegal_o=1, ALU_Operation_o=0; without M_EXT_EN, f7=0000001 f3=000 -> illegal_o=1, busy_o stays 0.
REQ-037 SHALL cover: reset asserted mid-RUN -> next cycle all outputs at reset values.
